// File: rtl/tpu.sv
//==============================================================================
// Module      : tpu
// Description : Weight-stationary 4x4 systolic matrix-multiply array with
//               per-column normalized 8-bit pixel outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tpu #(
    parameter int bit_width = 16,
    parameter int acc_width = 40,
    parameter int NORM_DIV  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      control,
    input  logic [4*bit_width-1:0]    data_arr,
    input  logic [4*bit_width-1:0]    wt_arr,
    output logic [4*acc_width-1:0]    acc_out,
    output logic [acc_width-1:0]      pe30_out,
    output logic [acc_width-1:0]      pe31_out,
    output logic [acc_width-1:0]      pe32_out,
    output logic [acc_width-1:0]      pe33_out,
    output logic [7:0]                pe30_norm_out,
    output logic [7:0]                pe31_norm_out,
    output logic [7:0]                pe32_norm_out,
    output logic [7:0]                pe33_norm_out
);

    localparam int                     c_ext      = acc_width - 2*bit_width;
    localparam logic signed [acc_width-1:0] c_norm_div = acc_width'(NORM_DIV);
    localparam logic signed [acc_width-1:0] c_max      = acc_width'(255);

    logic signed [bit_width-1:0] r_w   [0:3][0:3];
    logic signed [bit_width-1:0] r_d   [0:3][0:3];
    logic signed [acc_width-1:0] r_p   [0:3][0:3];
    logic signed [bit_width-1:0] w_din [0:3][0:3];
    logic signed [acc_width-1:0] w_sum [0:3][0:3];
    logic        [7:0]           w_norm [0:3];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_row
            for (genvar j = 0; j < 4; j++) begin : g_col
                logic signed [2*bit_width-1:0] w_prod;

                if (j == 0) begin : g_din_edge
                    assign w_din[i][j] = data_arr[i*bit_width +: bit_width];
                end else begin : g_din_shift
                    assign w_din[i][j] = r_d[i][j-1];
                end

                assign w_prod = w_din[i][j] * r_w[i][j];

                if (i == 0) begin : g_sum_top
                    assign w_sum[i][j] = {{c_ext{w_prod[2*bit_width-1]}}, w_prod};
                end else begin : g_sum_chain
                    assign w_sum[i][j] = r_p[i-1][j] + {{c_ext{w_prod[2*bit_width-1]}}, w_prod};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_w[i][j] <= '0;
                    r_d[i][j] <= '0;
                    r_p[i][j] <= '0;
                end
            end
        end else if (control) begin
            // Weights enter at the top row and march down one row per edge.
            for (int j = 0; j < 4; j++) begin
                r_w[0][j] <= wt_arr[j*bit_width +: bit_width];
            end
            for (int i = 1; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_w[i][j] <= r_w[i-1][j];
                end
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_d[i][j] <= '0;
                    r_p[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_d[i][j] <= w_din[i][j];
                    r_p[i][j] <= w_sum[i][j];
                end
            end
        end
    end

    // Truncating signed divide, then clamp into the 0..255 pixel range.
    generate
        for (genvar j = 0; j < 4; j++) begin : g_norm
            logic signed [acc_width-1:0] w_q;
            assign w_q       = r_p[3][j] / c_norm_div;
            assign w_norm[j] = w_q[acc_width-1] ? 8'd0 :
                               (w_q > c_max)    ? 8'hFF : w_q[7:0];
        end
    endgenerate

    assign pe30_out      = r_p[3][0];
    assign pe31_out      = r_p[3][1];
    assign pe32_out      = r_p[3][2];
    assign pe33_out      = r_p[3][3];
    assign acc_out       = {pe33_out, pe32_out, pe31_out, pe30_out};
    assign pe30_norm_out = w_norm[0];
    assign pe31_norm_out = w_norm[1];
    assign pe32_norm_out = w_norm[2];
    assign pe33_norm_out = w_norm[3];

endmodule

`default_nettype wire

// File: tb/tb_tpu.sv
//==============================================================================
// Module      : tb_tpu
// Description : Randomized self-checking bench for the 4x4 systolic tpu.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tpu;

    logic         clk;
    logic         rst_n;
    logic         control;
    logic [63:0]  data_arr;
    logic [63:0]  wt_arr;
    logic [159:0] acc_out;
    logic [39:0]  pe30_out, pe31_out, pe32_out, pe33_out;
    logic [7:0]   pe30_norm_out, pe31_norm_out, pe32_norm_out, pe33_norm_out;

    tpu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .control       (control),
        .data_arr      (data_arr),
        .wt_arr        (wt_arr),
        .acc_out       (acc_out),
        .pe30_out      (pe30_out),
        .pe31_out      (pe31_out),
        .pe32_out      (pe32_out),
        .pe33_out      (pe33_out),
        .pe30_norm_out (pe30_norm_out),
        .pe31_norm_out (pe31_norm_out),
        .pe32_norm_out (pe32_norm_out),
        .pe33_norm_out (pe33_norm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [39:0] outs  [4];
    logic [7:0]  norms [4];
    always_comb begin
        outs[0]  = pe30_out;      outs[1]  = pe31_out;
        outs[2]  = pe32_out;      outs[3]  = pe33_out;
        norms[0] = pe30_norm_out; norms[1] = pe31_norm_out;
        norms[2] = pe32_norm_out; norms[3] = pe33_norm_out;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: the current weight matrix, per-edge input history and
    // the index of the most recent edge that flushed the pipeline.
    shortint W    [0:3][0:3];
    shortint hist [0:1023][0:3];
    int      n       = 0;
    int      lastclr = 0;
    shortint vecs [0:15][0:3];
    int      nvec    = 0;

    task automatic step(input logic c, input logic rn, input logic [63:0] da,
                        input logic [63:0] wa);
        control  = c;
        rst_n    = rn;
        data_arr = da;
        wt_arr   = wa;
        @(posedge clk);
        n++;
        for (int r = 0; r < 4; r++) hist[n][r] = shortint'(da[16*r +: 16]);
        if (!rn) begin
            lastclr = n;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) W[i][j] = 0;
        end else if (c) begin
            lastclr = n;
            for (int i = 3; i > 0; i--)
                for (int j = 0; j < 4; j++) W[i][j] = W[i-1][j];
            for (int j = 0; j < 4; j++) W[0][j] = shortint'(wa[16*j +: 16]);
        end
        #1;
    endtask

    // Column j sums x_i * W[i][j] over the vector whose row-i element entered
    // 3-i+j edges ago, provided no flush happened since it entered.
    function automatic longint exp_sum(int j);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            int src = n - 3 + i - j;
            if (src > lastclr) s += longint'(hist[src][i]) * longint'(W[i][j]);
        end
        return s;
    endfunction

    function automatic logic [39:0] exp_p(int j);
        longint s = exp_sum(j);
        return s[39:0];
    endfunction

    function automatic logic [7:0] exp_n(int j);
        longint q = exp_sum(j) / 10;
        if (q < 0)   return 8'd0;
        if (q > 255) return 8'd255;
        return 8'(q);
    endfunction

    function automatic logic [63:0] skew_word(int e);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int v = e - i;
            if (v >= 0 && v < nvec) r[16*i +: 16] = vecs[v][i];
        end
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 2; k++)
            step(1'($urandom_range(0, 1)), 1'b0, rnd64(), rnd64());
        checks++;
        if (acc_out !== 160'd0) begin
            failures++;
            $display("FAIL reset_acc_out got=%h want=0", acc_out);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (outs[j] !== 40'd0) begin
                failures++;
                $display("FAIL reset_pe3%0d_out got=%h want=0", j, outs[j]);
            end
            checks++;
            if (norms[j] !== 8'd0) begin
                failures++;
                $display("FAIL reset_pe3%0d_norm got=%0d want=0", j, norms[j]);
            end
        end
    endtask

    task automatic load_identity10();
        for (int k = 0; k < 4; k++) begin
            logic [63:0] w = '0;
            w[16*(3-k) +: 16] = 16'h000a;
            step(1'b1, 1'b1, rnd64(), w);
            checks++;
            if (acc_out !== 160'd0) begin
                failures++;
                $display("FAIL load_clears_acc edge=%0d got=%h want=0", k, acc_out);
            end
        end
    endtask

    task automatic test_stream();
        int p0[4] = '{0, 10, 20, 30};
        int p3[4] = '{120, 130, 140, 300};
        int n3[4] = '{12, 13, 14, 30};
        load_identity10();
        for (int i = 0; i < 4; i++)
            for (int v = 0; v < 4; v++)
                vecs[v][i] = shortint'(i*4 + v);
        vecs[3][3] = 30;
        nvec = 4;
        for (int e = 0; e < 12; e++) begin
            step(1'b0, 1'b1, skew_word(e), rnd64());
            if (e >= 3 && e <= 6) begin
                checks++;
                if (pe30_out !== 40'(p0[e-3])) begin
                    failures++;
                    $display("FAIL stream_pe30 e=%0d got=%0d want=%0d", e, pe30_out, p0[e-3]);
                end
            end
            if (e >= 6 && e <= 9) begin
                checks++;
                if (pe33_out !== 40'(p3[e-6])) begin
                    failures++;
                    $display("FAIL stream_pe33 e=%0d got=%0d want=%0d", e, pe33_out, p3[e-6]);
                end
                checks++;
                if (pe33_norm_out !== 8'(n3[e-6])) begin
                    failures++;
                    $display("FAIL stream_pe33_norm e=%0d got=%0d want=%0d", e, pe33_norm_out, n3[e-6]);
                end
            end
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (outs[j] !== exp_p(j)) begin
                    failures++;
                    $display("FAIL stream_model_p col=%0d e=%0d got=%h want=%h", j, e, outs[j], exp_p(j));
                end
            end
        end
    endtask

    task automatic load_single00(input logic [15:0] w00);
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 64'd0, (k == 3) ? {48'd0, w00} : 64'd0);
    endtask

    task automatic run_single(input logic [15:0] x, input logic [39:0] want_p,
                              input logic [7:0] want_n, input string tag);
        nvec = 1;
        vecs[0][0] = shortint'(x);
        for (int i = 1; i < 4; i++) vecs[0][i] = 0;
        for (int e = 0; e < 5; e++) begin
            step(1'b0, 1'b1, skew_word(e), 64'd0);
            if (e == 3) begin
                checks++;
                if (pe30_out !== want_p) begin
                    failures++;
                    $display("FAIL %s_pe30 got=%h want=%h", tag, pe30_out, want_p);
                end
                checks++;
                if (pe30_norm_out !== want_n) begin
                    failures++;
                    $display("FAIL %s_norm got=%0d want=%0d", tag, pe30_norm_out, want_n);
                end
            end
        end
    endtask

    task automatic test_signed_clamp();
        load_single00(16'hFFFF);
        run_single(16'd50, 40'hFF_FFFF_FFCE, 8'd0, "signed_neg");
        load_single00(16'd100);
        run_single(16'd100, 40'd10000, 8'd255, "clamp_high");
    endtask

    task automatic test_full_matrix();
        for (int k = 0; k < 4; k++) begin
            logic [63:0] w;
            for (int j = 0; j < 4; j++)
                w[16*j +: 16] = 16'($signed($urandom_range(0, 20)) - 4);
            step(1'b1, 1'b1, rnd64(), w);
        end
        nvec = 8;
        for (int v = 0; v < 8; v++)
            for (int i = 0; i < 4; i++)
                vecs[v][i] = shortint'($signed($urandom_range(0, 220)) - 20);
        for (int e = 0; e < 16; e++) begin
            step(1'b0, 1'b1, skew_word(e), rnd64());
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (outs[j] !== exp_p(j)) begin
                    failures++;
                    $display("FAIL full_p col=%0d e=%0d got=%h want=%h", j, e, outs[j], exp_p(j));
                end
                checks++;
                if (norms[j] !== exp_n(j)) begin
                    failures++;
                    $display("FAIL full_norm col=%0d e=%0d got=%0d want=%0d", j, e, norms[j], exp_n(j));
                end
            end
        end
    endtask

    task automatic test_midstream_pulse();
        nvec = 12;
        for (int v = 0; v < 12; v++)
            for (int i = 0; i < 4; i++)
                vecs[v][i] = shortint'($urandom);
        for (int e = 0; e < 20; e++) begin
            if (e == 6) begin
                step(1'b1, 1'b1, skew_word(e), rnd64());
                checks++;
                if (acc_out !== 160'd0) begin
                    failures++;
                    $display("FAIL pulse_clear got=%h want=0", acc_out);
                end
            end else begin
                step(1'b0, 1'b1, skew_word(e), rnd64());
            end
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (outs[j] !== exp_p(j)) begin
                    failures++;
                    $display("FAIL pulse_p col=%0d e=%0d got=%h want=%h", j, e, outs[j], exp_p(j));
                end
                checks++;
                if (norms[j] !== exp_n(j)) begin
                    failures++;
                    $display("FAIL pulse_norm col=%0d e=%0d got=%0d want=%0d", j, e, norms[j], exp_n(j));
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        step(1'b0, 1'b0, rnd64(), rnd64());
        checks++;
        if (acc_out !== 160'd0) begin
            failures++;
            $display("FAIL midrun_reset got=%h want=0", acc_out);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        control  = 1'b0;
        data_arr = '0;
        wt_arr   = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) W[i][j] = 0;
        test_reset();
        test_stream();
        test_signed_clamp();
        test_full_matrix();
        test_midstream_pulse();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
